// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, one-cycle
// rx_finish / rx_frame_err pulses, break-safe recovery through WAIT_HIGH.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_finish,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned INDEX_W = 3;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync_meta;
    logic                 sync_rx;
    logic [TIMER_W-1:0]   timer;
    logic [INDEX_W-1:0]   bit_index;
    logic [7:0]           shift_reg;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_rx   <= 1'b1;
        end else begin
            sync_meta <= rx_serial;
            sync_rx   <= sync_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            bit_index    <= '0;
            shift_reg    <= '0;
            rx_byte      <= '0;
            rx_finish    <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_finish    <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer     <= '0;
                    bit_index <= '0;
                    if (sync_rx == 1'b0) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                // Re-check the start bit at its midpoint to reject glitches.
                START: begin
                    if (timer == HALF_BIT) begin
                        timer <= '0;
                        if (sync_rx == 1'b0) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer                <= '0;
                        shift_reg[bit_index] <= sync_rx;
                        if (bit_index == LAST_IDX) begin
                            bit_index <= '0;
                            state     <= STOP;
                        end else begin
                            bit_index <= bit_index + INDEX_W'(1);
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                // rx_byte only changes here, so mid-frame bits never leak out.
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (sync_rx == 1'b1) begin
                            rx_byte   <= shift_reg;
                            rx_finish <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                CLEANUP: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
                // A held-low line must return high before a new start is accepted.
                WAIT_HIGH: begin
                    if (sync_rx == 1'b1) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at CLKS_PER_BIT=16 with a byte scoreboard.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_finish;
    logic       rx_frame_err;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;

    int fin_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int stray_cnt = 0;
    bit busy_seen = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic reset_d = 1'b1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_serial    (rx_serial),
        .rx_byte      (rx_byte),
        .rx_finish    (rx_finish),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clock = ~clock;

    // Output monitor on the falling edge: collects received bytes and events.
    always @(negedge clock) begin
        if (!reset && !reset_d) begin
            if (rx_finish === 1'b1) begin
                fin_cnt++;
                got_q.push_back(rx_byte);
            end
            if (rx_frame_err === 1'b1) err_cnt++;
            if (rx_finish === 1'b1 && rx_frame_err === 1'b1) overlap_cnt++;
            if (rx_byte !== prev_byte && rx_finish !== 1'b1) stray_cnt++;
            if (rx_busy === 1'b1) busy_seen = 1'b1;
        end
        prev_byte = rx_byte;
        reset_d   = reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input bit expect_ok);
        if (expect_ok) exp_q.push_back(b);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            tick(CPB);
        end
        rx_serial = stop;
        tick(CPB);
        rx_serial = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_serial = 1'b1;
        tick(3);
        checks++;
        if (rx_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_byte got=%h exp=00", rx_byte);
        end
        checks++;
        if ({rx_finish, rx_frame_err, rx_busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {rx_finish, rx_frame_err, rx_busy});
        end
        reset = 1'b0;
        busy_seen = 1'b0;
        tick(6);
        checks++;
        if (busy_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b exp=0", busy_seen);
        end
    endtask

    task automatic test_single();
        int f0 = fin_cnt;
        int e0 = err_cnt;
        logic [7:0] e, g;
        drive_frame(8'h57, 1'b1, 1'b1);
        tick(CPB);
        checks++;
        if (fin_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL single_finish_count got=%0d exp=1", fin_cnt - f0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL single_frame_err got=%0d exp=0", err_cnt - e0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL single_byte got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL single_byte got=%h exp=%h", g, e);
                end
            end
        end
        checks++;
        if (rx_busy !== 1'b0 || rx_byte !== 8'h57) begin
            failures++;
            $display("FAIL single_after got busy=%b byte=%h exp busy=0 byte=57", rx_busy, rx_byte);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = fin_cnt;
        logic [7:0] e, g;
        drive_frame(8'h2D, 1'b1, 1'b1);
        drive_frame(8'h57, 1'b1, 1'b1);
        drive_frame(8'h0A, 1'b1, 1'b1);
        tick(CPB);
        checks++;
        if (fin_cnt - f0 !== 3) begin
            failures++;
            $display("FAIL b2b_finish_count got=%0d exp=3", fin_cnt - f0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_byte got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL b2b_byte got=%h exp=%h", g, e);
                end
            end
        end
        checks++;
        if (overlap_cnt !== 0 || stray_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_output_stability got overlap=%0d stray=%0d exp=0/0", overlap_cnt, stray_cnt);
        end
    endtask

    task automatic test_glitch();
        int f0 = fin_cnt;
        int e0 = err_cnt;
        busy_seen = 1'b0;
        rx_serial = 1'b0;
        tick(4);
        rx_serial = 1'b1;
        tick(2 * CPB);
        checks++;
        if (busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_pulse got=%b exp=1", busy_seen);
        end
        checks++;
        if (fin_cnt - f0 !== 0 || err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL glitch_no_output got fin=%0d err=%0d exp=0/0", fin_cnt - f0, err_cnt - e0);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_idle got busy=%b exp=0", rx_busy);
        end
    endtask

    task automatic test_frame_err();
        int f0 = fin_cnt;
        int e0 = err_cnt;
        drive_frame(8'hA5, 1'b0, 1'b0);
        rx_serial = 1'b0;
        tick(40);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL ferr_pulse_count got=%0d exp=1", err_cnt - e0);
        end
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_wait_high_busy got=%b exp=1", rx_busy);
        end
        rx_serial = 1'b1;
        tick(2 * CPB);
        checks++;
        if (fin_cnt - f0 !== 0 || err_cnt - e0 !== 1 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_after_break got fin=%0d err=%0d busy=%b exp=0/1/0",
                     fin_cnt - f0, err_cnt - e0, rx_busy);
        end
        checks++;
        if (rx_byte !== 8'h0A || stray_cnt !== 0) begin
            failures++;
            $display("FAIL ferr_byte_kept got=%h stray=%0d exp=0a/0", rx_byte, stray_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int f0 = fin_cnt;
        int e0 = err_cnt;
        logic [7:0] frame = 8'h3C;
        logic [7:0] e, g;
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial = frame[i];
            tick(CPB);
        end
        rx_serial = frame[4];
        tick(CPB / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rx_serial = 1'b1;
        tick(3 * CPB);
        checks++;
        if (fin_cnt - f0 !== 0 || err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL abort_no_output got fin=%0d err=%0d exp=0/0", fin_cnt - f0, err_cnt - e0);
        end
        checks++;
        if (rx_byte !== 8'h00 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got byte=%h busy=%b exp=00/0", rx_byte, rx_busy);
        end
        drive_frame(8'h31, 1'b1, 1'b1);
        tick(CPB);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL abort_next_byte got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL abort_next_byte got=%h exp=%h", g, e);
                end
            end
        end
        checks++;
        if (fin_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL abort_next_count got=%0d exp=1", fin_cnt - f0);
        end
    endtask

    task automatic test_latency(input logic [7:0] b);
        int lat = 0;
        logic [7:0] e, g;
        fork
            drive_frame(b, 1'b1, 1'b1);
            begin
                for (int n = 1; n <= 300; n++) begin
                    @(posedge clock);
                    #1;
                    if (rx_finish === 1'b1) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        tick(CPB);
        checks++;
        if (lat < 153 || lat > 155) begin
            failures++;
            $display("FAIL latency_%h got=%0d exp=154+/-1", b, lat);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL latency_byte got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL latency_byte got=%h exp=%h", g, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
        test_latency(8'h00);
        test_latency(8'hFF);
        checks++;
        if (got_q.size() != 0 || overlap_cnt !== 0) begin
            failures++;
            $display("FAIL final_leftover got extra=%0d overlap=%0d exp=0/0", got_q.size(), overlap_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 The module SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port rx_serial, input, 1, asynchronous serial line (8N1, LSB first, idle high).
REQ-005 The module SHALL have port rx_byte, output, 8, last correctly framed received byte.
REQ-006 The module SHALL have port rx_finish, output, 1, one-cycle pulse when rx_byte has been updated with a new byte.
REQ-007 The module SHALL have port rx_frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-008 The module SHALL have port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-009 rx_serial SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (sync_rx), giving 2 cycles of input latency.
REQ-010 The state machine SHALL have states IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH.
REQ-011 IDLE: a 16-bit bit-timer and 3-bit bit-index SHALL be held at 0; sync_rx==0 SHALL move to START.
REQ-012 START: the timer SHALL count up to (CLKS_PER_BIT-1)/2 (integer division); at that count, sync_rx==0 SHALL move to DATA with the timer cleared, and sync_rx==1 SHALL return to IDLE (glitch rejection, no output activity).
REQ-013 DATA: the timer SHALL count 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1, sync_rx SHALL be written into shift_reg[bit_index] and the timer cleared; bit_index 0..6 SHALL increment, and bit_index 7 SHALL reset it to 0 and move to STOP.
REQ-014 STOP: at timer CLKS_PER_BIT-1, sync_rx==1 SHALL load rx_byte<=shift_reg, assert rx_finish, and move to CLEANUP; sync_rx==0 SHALL assert rx_frame_err, leave rx_byte unchanged, and move to WAIT_HIGH.
REQ-015 rx_finish and rx_frame_err SHALL each be high for exactly one cycle, never simultaneously, and registered with the state transition out of STOP.
REQ-016 CLEANUP SHALL last exactly one cycle and then go to IDLE; this allows back-to-back frames with the minimum one stop bit.
REQ-017 WAIT_HIGH SHALL remain until sync_rx==1 and then go to IDLE, so that a held-low (break) line produces exactly one rx_frame_err and no false start.
REQ-018 rx_byte SHALL be stable between rx_finish pulses; the shift register SHALL not be visible at the output mid-frame.
REQ-019 Latency SHALL be: rx_finish asserted 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (+/-1 for start-edge alignment) after the falling edge of the start bit on rx_serial.
REQ-020 The timer SHALL never wrap; its width SHALL hold CLKS_PER_BIT-1.

Reset
REQ-021 While reset==1 on a rising edge, the state SHALL become IDLE, the timer, bit_index, shift_reg and rx_byte SHALL become 0, rx_finish, rx_frame_err and rx_busy SHALL become 0, and both synchronizer flops SHALL become 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no rx_finish or rx_frame_err; reception SHALL restart only on a new falling edge after reset deasserts.

Verification (bench with CLKS_PER_BIT=16)
REQ-023 Drive 0x57 ('W') framed 8N1 -> exactly one rx_finish pulse, rx_byte==0x57, rx_frame_err stays 0, rx_busy low afterwards.
REQ-024 Drive '-', 'W', '\n' (0x2D, 0x57, 0x0A) back-to-back with one stop bit each -> three rx_finish pulses with rx_byte 0x2D, 0x57, 0x0A in order, none dropped.
REQ-025 Drive a 4-cycle low glitch on an idle line -> rx_busy pulses high briefly, no rx_finish, no rx_frame_err, state returns to IDLE.
REQ-026 Drive 0xA5 with stop bit 0, then hold the line low 40 cycles, then high -> one rx_frame_err pulse, rx_finish 0, rx_byte keeps its previous value, no new frame until the line goes high then low.
REQ-027 Assert reset for 1 cycle during data bit 4 of 0x3C, then send 0x31 -> no output from the aborted frame, then rx_finish with rx_byte==0x31.
REQ-028 Measure from the start-bit falling edge to the rx_finish pulse for 0x00 and 0xFF -> latency within REQ-019 bounds, i.e. 154 +/-1 cycles.
